// File: rtl/ram_burst_master.sv
// Burst initiator for one port of the 8x8 dual-port RAM: accepts valid/ready
// burst commands, streams write beats in, and returns read data as pulses.
module ram_burst_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]        state_q,       state_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic [LEN_W-1:0]  cnt_q,         cnt_d;
  logic              req_ready_q,   req_ready_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic              busy_q,        busy_d;
  logic              ram_en_q,      ram_en_d;
  logic              ram_we_q,      ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q,   ram_wdata_d;
  logic              ram_last_q,    ram_last_d;
  logic              rd_p1_q,       rd_p1_d;
  logic              rd_p1_last_q,  rd_p1_last_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              done_q,        done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_last_d  = 1'b0;
    done_d      = 1'b0;

    // Read beat on the port -> RAM output next cycle -> captured one cycle later.
    rd_p1_d      = ram_en_q & ~ram_we_q;
    rd_p1_last_d = ram_en_q & ~ram_we_q & ram_last_q;
    rsp_valid_d  = rd_p1_q;
    rsp_rdata_d  = rd_p1_q ? ram_rdata : rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          cnt_d  = req_len;
          if (req_we) begin
            state_d = ST_WR;
          end else begin
            // Beat 0 is issued straight from acceptance; cnt then counts beats still to issue.
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = req_addr;
            ram_last_d = (req_len == '0);
            addr_d     = req_addr + 1'b1;
            state_d    = (req_len == '0) ? ST_DRAIN : ST_RD;
          end
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = wdata;
          addr_d      = addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_RD: begin
        ram_en_d   = 1'b1;
        ram_we_d   = 1'b0;
        ram_addr_d = addr_q;
        addr_d     = addr_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          ram_last_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_p1_q && rd_p1_last_q) done_d = 1'b1;

    // Status outputs are flopped from the next state so they read 0 while in reset.
    req_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_WR);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_last_q    <= 1'b0;
      rd_p1_q       <= 1'b0;
      rd_p1_last_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      busy_q        <= busy_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_last_q    <= ram_last_d;
      rd_p1_q       <= rd_p1_d;
      rd_p1_last_q  <= rd_p1_last_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      done_q        <= done_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign busy        = busy_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: attached 8x8 registered-output RAM, a table of
// directed bursts, hand-written reset/busy sequences, then random bursts.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = '0;
  logic [2:0] req_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       done;
  logic       busy;
  logic       ram_en;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       mem_clr = 1'b1;

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_W(8), .ADDR_W(3), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .done(done), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM port with registered read data
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  logic [7:0] ref_mem [8];
  logic [7:0] wbuf [8];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    bit         we;
    logic [2:0] addr;
    logic [2:0] len;
    logic [7:0] base;
    logic [15:0] vpat;
    int         exp_turn;
    logic [7:0] exp_first;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (req_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_ready", 32'(req_ready), 32'd1);
  endtask

  // Read burst timing from acceptance edge: beat k on port at t=1+k,
  // response at t=3+k, done with last response, req_ready at t=N+3.
  task automatic do_read(input logic [2:0] addr, input logic [2:0] len,
                         output int turn, output logic [7:0] first);
    int n = int'(len) + 1;
    logic [2:0] a;
    turn  = -1;
    first = 'x;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
    tick();
    req_valid = 1'b0;
    for (int t = 1; t <= n + 3; t++) begin
      chk("rd_ram_en", 32'(ram_en), 32'(t <= n));
      if (t <= n) begin
        a = addr + 3'(t - 1);
        chk("rd_ram_addr", 32'(ram_addr), 32'(a));
        chk("rd_ram_we", 32'(ram_we), 32'd0);
      end
      chk("rd_rsp_valid", 32'(rsp_valid), 32'(t >= 3 && t <= n + 2));
      if (t >= 3 && t <= n + 2) begin
        a = addr + 3'(t - 3);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'(ref_mem[a]));
        if (t == 3) first = rsp_rdata;
      end
      chk("rd_done", 32'(done), 32'(t == n + 2));
      chk("rd_req_ready", 32'(req_ready), 32'(t == n + 3));
      chk("rd_busy", 32'(busy), 32'(t != n + 3));
      if (req_ready && turn < 0) turn = t;
      if (t < n + 3) tick();
    end
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [2:0] len,
                          input logic [15:0] vpat, input bit use_rand, output int turn);
    int beats_left = int'(len) + 1;
    int k = 0;
    bit prev_hs = 1'b0;
    bit prev_last = 1'b0;
    bit wv;
    logic [2:0] pa = '0;
    logic [7:0] pd = '0;
    turn = -1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
    tick();
    req_valid = 1'b0;
    for (int t = 1; t <= 64; t++) begin
      chk("wr_ram_en", 32'(ram_en), 32'(prev_hs));
      if (prev_hs) begin
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'(pa));
        chk("wr_ram_wdata", 32'(ram_wdata), 32'(pd));
      end
      chk("wr_done", 32'(done), 32'(prev_last));
      chk("wr_req_ready", 32'(req_ready), 32'(beats_left == 0));
      chk("wr_wdata_ready", 32'(wdata_ready), 32'(beats_left > 0));
      if (beats_left == 0) begin
        turn = t;
        break;
      end
      wv = use_rand ? ($urandom_range(0, 3) != 0) : ((t > 16) ? 1'b1 : vpat[t-1]);
      wdata_valid = wv;
      wdata = wbuf[3'(k)];
      prev_hs = wv;
      prev_last = 1'b0;
      if (wv) begin
        pa = addr + 3'(k);
        pd = wbuf[3'(k)];
        ref_mem[pa] = pd;
        k++;
        beats_left--;
        prev_last = (beats_left == 0);
      end
      tick();
    end
    wdata_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int turn;
    int gap;
    int acc;
    logic [7:0] first;
    logic [2:0] ra, rl;

    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    tbl[0] = '{1'b1, 3'd5, 3'd0, 8'hA5, 16'hFFFF, 2,  8'h00};
    tbl[1] = '{1'b0, 3'd5, 3'd0, 8'h00, 16'h0000, 4,  8'hA5};
    tbl[2] = '{1'b1, 3'd6, 3'd7, 8'h10, 16'hFFFF, 9,  8'h00};
    tbl[3] = '{1'b0, 3'd6, 3'd7, 8'h00, 16'h0000, 11, 8'h10};
    tbl[4] = '{1'b1, 3'd1, 3'd2, 8'h30, 16'h0019, 6,  8'h00};
    tbl[5] = '{1'b0, 3'd1, 3'd2, 8'h00, 16'h0000, 6,  8'h30};

    // Reset held with a pending request
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; req_len = 3'd2;
    wdata_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    end
    rst_n = 1'b1; mem_clr = 1'b0;
    tick();
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_ram_en", 32'(ram_en), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    req_valid = 1'b0; wdata_valid = 1'b0;
    tick();
    chk("rel_ram_en2", 32'(ram_en), 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].we) begin
        for (int k = 0; k < 8; k++) wbuf[k] = tbl[i].base + 8'(k);
        do_write(tbl[i].addr, tbl[i].len, tbl[i].vpat, 1'b0, turn);
      end else begin
        do_read(tbl[i].addr, tbl[i].len, turn, first);
        chk("tbl_first_rdata", 32'(first), 32'(tbl[i].exp_first));
      end
      chk("tbl_turnaround", 32'(turn), 32'(tbl[i].exp_turn));
    end

    // Reset during the second beat of a 5-beat read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0; req_len = 3'd4;
    tick();
    req_valid = 1'b0;
    chk("mid_beat0", 32'(ram_en), 32'd1);
    tick();
    chk("mid_beat1_addr", 32'(ram_addr), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_ram_en", 32'(ram_en), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_quiet_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_quiet_done", 32'(done), 32'd0);
      chk("mid_quiet_en", 32'(ram_en), 32'd0);
      tick();
    end
    do_read(3'd5, 3'd0, turn, first);
    chk("mid_new_turn", 32'(turn), 32'd4);

    // req_valid held through a 4-beat read: exactly one extra acceptance
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2; req_len = 3'd3;
    acc = 0;
    for (int t = 0; t <= 8; t++) begin
      if (t >= 1 && t <= 6) chk("bi_ready_low", 32'(req_ready), 32'd0);
      if (t == 7) chk("bi_ready_high", 32'(req_ready), 32'd1);
      if (t == 8) chk("bi_ready_again", 32'(req_ready), 32'd0);
      if (t >= 1 && t <= 7) chk("bi_done", 32'(done), 32'(t == 6));
      if (req_valid && req_ready) acc++;
      tick();
      if (t == 7) req_valid = 1'b0;
    end
    chk("bi_acceptances", 32'(acc), 32'd2);
    wait_ready(20);

    // Random bursts against the reference memory
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        wdata_valid = 1'($urandom_range(0, 1));
        tick();
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end
      wdata_valid = 1'b0;
      ra = 3'($urandom);
      rl = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
        do_write(ra, rl, 16'hFFFF, 1'b1, turn);
        chk("rnd_wr_turn_seen", 32'(turn > 0), 32'd1);
      end else begin
        do_read(ra, rl, turn, first);
        chk("rnd_rd_turn", 32'(turn), 32'(int'(rl) + 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
